// File: rtl/glyph_rom_pkg.sv
// Shared constants, pipeline tag type and address helpers for the glyph ROM arbiter.
package glyph_rom_pkg;

  localparam int unsigned GLYPH_DIM  = 50;
  localparam int unsigned NUM_GLYPHS = 10;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned GLYPH_W    = 4;
  localparam int unsigned COORD_W    = 6;
  localparam int unsigned ID_W       = 3;
  localparam int unsigned PIX_W      = 2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            oor;
  } req_tag_t;

  // Glyphs are stored back to back, row-major within each glyph.
  function automatic logic [ADDR_W-1:0] glyph_addr(
    input logic [GLYPH_W-1:0] glyph,
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py
  );
    logic [31:0] full;
    full = 32'(glyph) * 32'(GLYPH_DIM * GLYPH_DIM) + 32'(py) * 32'(GLYPH_DIM) + 32'(px);
    return ADDR_W'(full);
  endfunction

  function automatic logic glyph_oor(
    input logic [GLYPH_W-1:0] glyph,
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py
  );
    return (glyph >= GLYPH_W'(NUM_GLYPHS)) ||
           (px >= COORD_W'(GLYPH_DIM)) ||
           (py >= COORD_W'(GLYPH_DIM));
  endfunction

endpackage

// File: rtl/glyph_rom_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter
  import glyph_rom_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_gnt_c,
  output logic [ID_W-1:0]          o_id_c,
  output logic                     o_any_c
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt_c = '0;
    o_id_c  = '0;
    o_any_c = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % N_REQ);
      if (!o_any_c && i_req[w_idx]) begin
        o_gnt_c[w_idx] = 1'b1;
        o_id_c         = ID_W'(w_idx);
        o_any_c        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glyph_rom_arbiter.sv
// Shares one 2bpp glyph ROM between N_REQ requesters: round-robin grant,
// ROM address generation, and an id-tagged fixed-latency response pipeline.
module glyph_rom_arbiter
  import glyph_rom_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                     i_vga_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*GLYPH_W-1:0] i_glyph,
  input  logic [N_REQ*COORD_W-1:0] i_px,
  input  logic [N_REQ*COORD_W-1:0] i_py,
  output logic [N_REQ-1:0]         o_gnt_c,
  output logic                     o_rom_en,
  output logic [ADDR_W-1:0]        o_rom_addr,
  input  logic [PIX_W-1:0]         i_rom_q,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [PIX_W-1:0]         o_rsp_data
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]       r_ptr;
  logic                   r_rom_en;
  logic [ADDR_W-1:0]      r_rom_addr;
  req_tag_t [ROM_LAT:0]   r_pipe;
  logic                   r_rsp_valid;
  logic [ID_W-1:0]        r_rsp_id;
  logic [PIX_W-1:0]       r_rsp_data;

  logic [N_REQ-1:0]       w_arb_gnt;
  logic [ID_W-1:0]        w_arb_id;
  logic                   w_arb_any;
  logic                   w_any;
  logic [PTR_W-1:0]       w_win;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [GLYPH_W-1:0]     w_sel_glyph;
  logic [COORD_W-1:0]     w_sel_px;
  logic [COORD_W-1:0]     w_sel_py;
  logic                   w_oor;
  logic [ADDR_W-1:0]      w_addr;
  req_tag_t               w_tag;
  req_tag_t               w_out_tag;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_arb_gnt),
    .o_id_c  (w_arb_id),
    .o_any_c (w_arb_any)
  );

  // Reset masks the grant so nothing is accepted while the pipeline clears.
  assign o_gnt_c   = i_reset ? '0 : w_arb_gnt;
  assign w_any     = w_arb_any & ~i_reset;
  assign w_win     = PTR_W'(w_arb_id);
  assign w_ptr_nxt = (w_win == PTR_W'(N_REQ - 1)) ? '0 : w_win + PTR_W'(1);

  // Route the winner's glyph coordinates to the address logic.
  always_comb begin
    w_sel_glyph = '0;
    w_sel_px    = '0;
    w_sel_py    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_sel_glyph = i_glyph[i*GLYPH_W +: GLYPH_W];
        w_sel_px    = i_px[i*COORD_W +: COORD_W];
        w_sel_py    = i_py[i*COORD_W +: COORD_W];
      end
    end
  end

  assign w_oor  = glyph_oor(w_sel_glyph, w_sel_px, w_sel_py);
  assign w_addr = glyph_addr(w_sel_glyph, w_sel_px, w_sel_py);
  assign w_tag  = '{valid: w_any, id: w_arb_id, oor: w_oor};

  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Out-of-range accesses skip the ROM and leave the last address in place.
  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_rom_en <= w_any & ~w_oor;
      if (w_any && !w_oor) begin
        r_rom_addr <= w_addr;
      end
    end
  end

  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[ROM_LAT-1:0], w_tag};
    end
  end

  assign w_out_tag = r_pipe[ROM_LAT];

  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_out_tag.valid;
      r_rsp_id    <= w_out_tag.id;
      r_rsp_data  <= (w_out_tag.valid && !w_out_tag.oor) ? i_rom_q : '0;
    end
  end

  assign o_rom_en    = r_rom_en;
  assign o_rom_addr  = r_rom_addr;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

  a_gnt_onehot: assert property (@(posedge i_vga_clk) $onehot0(o_gnt_c));
  a_gnt_subset: assert property (@(posedge i_vga_clk) (o_gnt_c & ~i_req) == '0);

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Scoreboard bench for glyph_rom_arbiter with a registered one-cycle ROM model.
module tb_glyph_rom_arbiter;
  import glyph_rom_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          req;
  logic [15:0]         glyph;
  logic [23:0]         px;
  logic [23:0]         py;
  logic [3:0]          gnt;
  logic                rom_en;
  logic [ADDR_W-1:0]   rom_addr;
  logic [1:0]          rom_q = 2'b00;
  logic                rsp_valid;
  logic [2:0]          rsp_id;
  logic [1:0]          rsp_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int id;
    int data;
    int cyc;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glyph_rom_arbiter #(.N_REQ(4), .ROM_LAT(1)) dut (
    .i_vga_clk   (clk),
    .i_reset     (reset),
    .i_req       (req),
    .i_glyph     (glyph),
    .i_px        (px),
    .i_py        (py),
    .o_gnt_c     (gnt),
    .o_rom_en    (rom_en),
    .o_rom_addr  (rom_addr),
    .i_rom_q     (rom_q),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data)
  );

  function automatic logic [1:0] rom_word(input logic [ADDR_W-1:0] a);
    return a[1:0] ^ a[4:3] ^ a[10:9];
  endfunction

  always @(posedge clk) if (rom_en) rom_q <= rom_word(rom_addr);

  function automatic logic [ADDR_W-1:0] addr_f(input int g, input int x, input int y);
    return ADDR_W'(g * 2500 + y * 50 + x);
  endfunction

  function automatic logic [3:0] rr_model(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int j = (p + k) % 4;
      if (r[j]) return 4'(1 << j);
    end
    return 4'b0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: grant, ROM port and response expectations.
  logic              m_chk_rom = 1'b0;
  logic              m_en = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [3:0]        m_eg;
  logic              m_oor;
  int                m_ptr = 0;
  int                m_w, m_g, m_x, m_y;
  sb_t               m_e;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        m_e = sb_q.pop_front();
        check_eq("rsp_id", 32'(rsp_id), m_e.id);
        check_eq("rsp_data", 32'(rsp_data), m_e.data);
        check_eq("rsp_latency", cyc - m_e.cyc, 3);
      end
    end
    if (m_chk_rom) begin
      check_eq("rom_en", 32'(rom_en), 32'(m_en));
      check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
    end
    m_chk_rom = 1'b1;
    if (reset) begin
      check_eq("gnt_in_reset", 32'(gnt), 0);
      sb_q.delete();
      m_ptr  = 0;
      m_en   = 1'b0;
      m_addr = '0;
    end else begin
      m_eg = rr_model(req, m_ptr);
      check_eq("gnt", 32'(gnt), 32'(m_eg));
      m_en = 1'b0;
      if (m_eg != 4'b0000) begin
        m_w = 0;
        for (int j = 0; j < 4; j++) if (m_eg[j]) m_w = j;
        m_g   = 32'(glyph[m_w*4 +: 4]);
        m_x   = 32'(px[m_w*6 +: 6]);
        m_y   = 32'(py[m_w*6 +: 6]);
        m_oor = (m_g >= 10) || (m_x >= 50) || (m_y >= 50);
        m_e.id  = m_w;
        m_e.cyc = cyc;
        if (m_oor) begin
          m_e.data = 0;
        end else begin
          m_en     = 1'b1;
          m_addr   = addr_f(m_g, m_x, m_y);
          m_e.data = 32'(rom_word(m_addr));
        end
        sb_q.push_back(m_e);
        m_ptr = (m_w + 1) % 4;
      end
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input int i, input int g, input int x, input int y);
    glyph[i*4 +: 4] = 4'(g);
    px[i*6 +: 6]    = 6'(x);
    py[i*6 +: 6]    = 6'(y);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    glyph = '0;
    px    = '0;
    py    = '0;
    repeat (3) at_edge();
    reset = 1'b0;

    // Reset values
    @(negedge clk);
    check_eq("rst_rom_en", 32'(rom_en), 0);
    check_eq("rst_rom_addr", 32'(rom_addr), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_id", 32'(rsp_id), 0);
    check_eq("rst_rsp_data", 32'(rsp_data), 0);

    // Single access, glyph 3 (10,20)
    at_edge();
    set_f(0, 3, 10, 20);
    req = 4'b0001;
    @(negedge clk);
    check_eq("t1_gnt", 32'(gnt), 1);
    at_edge();
    req = 4'b0000;
    @(negedge clk);
    check_eq("t1_rom_en", 32'(rom_en), 1);
    check_eq("t1_rom_addr", 32'(rom_addr), 8510);
    at_edge();
    at_edge();
    @(negedge clk);
    check_eq("t1_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t1_rsp_id", 32'(rsp_id), 0);
    check_eq("t1_rsp_data", 32'(rsp_data), 32'(rom_word(ADDR_W'(8510))));

    // Bring ptr back to 0, then all four requesting for 8 cycles
    at_edge();
    req = 4'b1000;
    at_edge();
    set_f(0, 1, 0, 0);
    set_f(1, 4, 7, 33);
    set_f(2, 8, 45, 12);
    set_f(3, 6, 19, 2);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("t2_gnt_order", 32'(gnt), 32'(1 << (k % 4)));
      at_edge();
    end
    req = 4'b0000;
    repeat (4) at_edge();

    // ptr -> 2, then req=0101 alternates 2,0,2
    req = 4'b0010;
    @(negedge clk);
    check_eq("t3_pre_gnt", 32'(gnt), 2);
    at_edge();
    req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t3_gnt", 32'(gnt), (k == 1) ? 1 : 4);
      at_edge();
    end
    req = 4'b0000;
    repeat (3) at_edge();

    // Out-of-range glyph, then out-of-range px, on requester 1
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_f(1, 12, 5, 5);
      else        set_f(1, 2, 50, 7);
      req = 4'b0010;
      @(negedge clk);
      check_eq("t4_gnt", 32'(gnt), 2);
      at_edge();
      req = 4'b0000;
      @(negedge clk);
      check_eq("t4_rom_en", 32'(rom_en), 0);
      at_edge();
      at_edge();
      @(negedge clk);
      check_eq("t4_rsp_valid", 32'(rsp_valid), 1);
      check_eq("t4_rsp_id", 32'(rsp_id), 1);
      check_eq("t4_rsp_data", 32'(rsp_data), 0);
      at_edge();
    end

    // Last pixel of the last glyph
    set_f(2, 9, 49, 49);
    req = 4'b0100;
    at_edge();
    req = 4'b0000;
    @(negedge clk);
    check_eq("t5_rom_en", 32'(rom_en), 1);
    check_eq("t5_rom_addr", 32'(rom_addr), 24999);
    repeat (3) at_edge();

    // Reset returns ptr to 0
    reset = 1'b1;
    at_edge();
    reset = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    check_eq("t6_ptr_reset_gnt", 32'(gnt), 1);
    at_edge();
    req = 4'b0000;
    repeat (4) at_edge();

    // Reset one cycle after two grants discards both
    req = 4'b0011;
    at_edge();
    at_edge();
    req   = 4'b0000;
    reset = 1'b1;
    at_edge();
    at_edge();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("t7_no_rsp", 32'(rsp_valid), 0);
      at_edge();
    end
    req = 4'b1000;
    @(negedge clk);
    check_eq("t7_gnt_after_reset", 32'(gnt), 8);
    at_edge();
    req = 4'b0000;
    repeat (4) at_edge();

    // Random traffic, model checks every cycle
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++)
        set_f(i, $urandom_range(0, 11), $urandom_range(0, 52), $urandom_range(0, 52));
      req = 4'($urandom_range(0, 15));
      at_edge();
    end
    req = 4'b0000;
    repeat (8) at_edge();
    check_eq("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
